// File: rtl/sram_arb_pkg.sv
// Shared constants and grant encoding for the unified SRAM port arbiter.
// Imported by the arbiter and anything that decodes its grant state.
package sram_arb_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;

  localparam logic [3:0] WE_LOAD = 4'b0000;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_I,
    GNT_D
  } gnt_e;

endpackage

// File: rtl/sram_port_arbiter.sv
// Fetch/load-store arbiter for the single-port unified SRAM.
// D has fixed priority; an aging counter bounds how long I can starve.
module sram_port_arbiter #(
  parameter int ADDR_W   = sram_arb_pkg::ADDR_W,
  parameter int DATA_W   = sram_arb_pkg::DATA_W,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic [3:0]        d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [3:0]        sram_w_en,
  output logic [ADDR_W-1:0] sram_address,
  output logic [DATA_W-1:0] sram_write_data,
  input  logic [DATA_W-1:0] sram_read_data
);
  import sram_arb_pkg::*;

  gnt_e       gnt;
  logic [3:0] wait_cnt;
  logic       force_i;
  logic       d_load;
  logic       i_rvalid_q;
  logic       d_rvalid_q;

  assign force_i = (wait_cnt == 4'(MAX_WAIT));

  always_comb begin
    gnt = GNT_NONE;
    if (!rst) begin
      if (i_req && (force_i || !d_req))
        gnt = GNT_I;
      else if (d_req)
        gnt = GNT_D;
    end
  end

  assign i_gnt  = (gnt == GNT_I);
  assign d_gnt  = (gnt == GNT_D);
  assign d_load = d_gnt && (d_we == WE_LOAD);

  always_comb begin
    sram_address    = '0;
    sram_w_en       = WE_LOAD;
    sram_write_data = '0;
    unique case (gnt)
      GNT_I: sram_address = i_addr;
      GNT_D: begin
        sram_address    = d_addr;
        sram_w_en       = d_we;
        sram_write_data = d_wdata;
      end
      default: ;
    endcase
  end

  // A response pending across a reset edge must not reach the pipeline.
  assign i_rvalid = i_rvalid_q && !rst;
  assign d_rvalid = d_rvalid_q && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      i_rdata    <= '0;
      d_rdata    <= '0;
      wait_cnt   <= '0;
    end else begin
      i_rvalid_q <= i_gnt;
      d_rvalid_q <= d_load;
      if (i_gnt)
        i_rdata <= sram_read_data;
      if (d_load)
        d_rdata <= sram_read_data;
      if (!i_req || i_gnt)
        wait_cnt <= '0;
      else if (!force_i)
        wait_cnt <= wait_cnt + 4'd1;
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a byte-wide SRAM model.
// Expected values are hand-computed constants.
module tb_sram_port_arbiter;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic [15:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req;
  logic [3:0]  d_we;
  logic [15:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic [3:0]  sram_w_en;
  logic [15:0] sram_address;
  logic [31:0] sram_write_data;
  logic [31:0] sram_read_data;

  int vectors;
  int miscompares;

  logic [7:0] mem [65536];

  sram_port_arbiter #(
    .ADDR_W(16),
    .DATA_W(32),
    .MAX_WAIT(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_req(i_req),
    .i_addr(i_addr),
    .i_gnt(i_gnt),
    .i_rvalid(i_rvalid),
    .i_rdata(i_rdata),
    .d_req(d_req),
    .d_we(d_we),
    .d_addr(d_addr),
    .d_wdata(d_wdata),
    .d_gnt(d_gnt),
    .d_rvalid(d_rvalid),
    .d_rdata(d_rdata),
    .sram_w_en(sram_w_en),
    .sram_address(sram_address),
    .sram_write_data(sram_write_data),
    .sram_read_data(sram_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign sram_read_data = {mem[16'(sram_address + 16'd3)],
                           mem[16'(sram_address + 16'd2)],
                           mem[16'(sram_address + 16'd1)],
                           mem[sram_address]};

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++)
      if (sram_w_en[k])
        mem[16'(sram_address + 16'(k))] <= sram_write_data[8*k +: 8];
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  string pat;

  initial begin
    vectors     = 0;
    miscompares = 0;
    pat         = "DDDDIDDDDI";

    mem[16'h0200] <= 8'h04;
    mem[16'h0201] <= 8'h03;
    mem[16'h0202] <= 8'h02;
    mem[16'h0203] <= 8'h01;
    mem[16'h0010] <= 8'hEF;
    mem[16'h0011] <= 8'hBE;
    mem[16'h0012] <= 8'hAD;
    mem[16'h0013] <= 8'hDE;
    mem[16'h0100] <= 8'hDD;
    mem[16'h0101] <= 8'hCC;
    mem[16'h0102] <= 8'hBB;
    mem[16'h0103] <= 8'hAA;
    mem[16'hFFFE] <= 8'h11;
    mem[16'hFFFF] <= 8'h22;
    mem[16'h0000] <= 8'h33;
    mem[16'h0001] <= 8'h44;

    rst     = 1'b1;
    i_req   = 1'b1;
    i_addr  = 16'h0000;
    d_req   = 1'b1;
    d_we    = 4'hF;
    d_addr  = 16'h0200;
    d_wdata = 32'hFFFF_FFFF;

    for (int c = 0; c < 2; c++) begin
      tick();
      chk("rst_i_gnt", 32'(i_gnt), 32'd0);
      chk("rst_d_gnt", 32'(d_gnt), 32'd0);
      chk("rst_w_en", 32'(sram_w_en), 32'd0);
      chk("rst_i_rvalid", 32'(i_rvalid), 32'd0);
      chk("rst_d_rvalid", 32'(d_rvalid), 32'd0);
    end
    chk("rst_i_rdata", i_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    chk("rst_mem_kept", {mem[16'h0203], mem[16'h0202],
                         mem[16'h0201], mem[16'h0200]}, 32'h0102_0304);

    // fetch only
    rst    = 1'b0;
    d_req  = 1'b0;
    d_we   = 4'h0;
    i_req  = 1'b1;
    i_addr = 16'h0010;
    #1;
    chk("ionly_i_gnt", 32'(i_gnt), 32'd1);
    chk("ionly_d_gnt", 32'(d_gnt), 32'd0);
    chk("ionly_addr", 32'(sram_address), 32'h0010);
    chk("ionly_w_en", 32'(sram_w_en), 32'd0);
    tick();
    chk("ionly_rvalid", 32'(i_rvalid), 32'd1);
    chk("ionly_rdata", i_rdata, 32'hDEAD_BEEF);

    // partial store then load of same word
    i_req   = 1'b0;
    d_req   = 1'b1;
    d_we    = 4'b0011;
    d_addr  = 16'h0100;
    d_wdata = 32'h1234_5678;
    #1;
    chk("st_d_gnt", 32'(d_gnt), 32'd1);
    chk("st_w_en", 32'(sram_w_en), 32'h3);
    chk("st_wdata", sram_write_data, 32'h1234_5678);
    chk("st_addr", 32'(sram_address), 32'h0100);
    tick();
    chk("st_no_rvalid", 32'(d_rvalid), 32'd0);
    chk("st_i_rvalid_low", 32'(i_rvalid), 32'd0);
    d_we = 4'b0000;
    #1;
    chk("ld_w_en", 32'(sram_w_en), 32'd0);
    tick();
    chk("ld_rvalid", 32'(d_rvalid), 32'd1);
    chk("ld_rdata", d_rdata, 32'hAABB_5678);
    chk("ld_i_rdata_held", i_rdata, 32'hDEAD_BEEF);

    // continuous contention: D x4 then forced I
    i_req  = 1'b1;
    i_addr = 16'h0010;
    d_req  = 1'b1;
    d_we   = 4'b0000;
    d_addr = 16'h0100;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk($sformatf("cont%0d_i_gnt", k), 32'(i_gnt),
          32'(pat[k] == "I"));
      chk($sformatf("cont%0d_d_gnt", k), 32'(d_gnt),
          32'(pat[k] == "D"));
      tick();
      chk($sformatf("cont%0d_i_rvalid", k), 32'(i_rvalid),
          32'(pat[k] == "I"));
      chk($sformatf("cont%0d_d_rvalid", k), 32'(d_rvalid),
          32'(pat[k] == "D"));
    end
    chk("cont_i_rdata", i_rdata, 32'hDEAD_BEEF);
    chk("cont_d_rdata", d_rdata, 32'hAABB_5678);

    // wrapping load
    i_req  = 1'b0;
    d_addr = 16'hFFFE;
    #1;
    chk("wrap_addr", 32'(sram_address), 32'hFFFE);
    tick();
    chk("wrap_rvalid", 32'(d_rvalid), 32'd1);
    chk("wrap_rdata", d_rdata, 32'h4433_2211);

    // idle drive
    d_req   = 1'b0;
    d_wdata = 32'hCAFE_F00D;
    d_we    = 4'hF;
    #1;
    chk("idle_gnt", {30'd0, i_gnt, d_gnt}, 32'd0);
    chk("idle_addr", 32'(sram_address), 32'd0);
    chk("idle_w_en", 32'(sram_w_en), 32'd0);
    chk("idle_wdata", sram_write_data, 32'd0);

    // reset right after a fetch grant
    d_we   = 4'h0;
    i_req  = 1'b1;
    i_addr = 16'h0010;
    #1;
    chk("rmid_i_gnt", 32'(i_gnt), 32'd1);
    tick();
    rst = 1'b1;
    #1;
    chk("rmid_i_rvalid_sq", 32'(i_rvalid), 32'd0);
    chk("rmid_i_gnt_rst", 32'(i_gnt), 32'd0);
    tick();
    chk("rmid_i_rvalid_after", 32'(i_rvalid), 32'd0);
    chk("rmid_wait_cnt", 32'(dut.wait_cnt), 32'd0);
    rst   = 1'b0;
    d_req = 1'b1;
    #1;
    chk("rmid_resume_d", 32'(d_gnt), 32'd1);
    chk("rmid_resume_i", 32'(i_gnt), 32'd0);
    tick();
    chk("rmid_resume_rv", 32'(d_rvalid), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
